multi_channel_moving_avg: RTL
=============================

// Module: multi_channel_moving_avg
// PURPOSE
//  Parametrised N-channel boxcar moving-average filter over a 2^LOG2_WIN-sample window.
//  Next generation of the 2-bit, 3-channel, fixed-window averager on the ui_in/uo_out pins.
//  Adds: parametrised width, depth and channel count; full-width sums (no wrap); valid handshake;
//  fill tracking; synchronous flush; raw-sum / rounded-average output mode.
//  Instantiated under the tt_um_* top-level wrapper; pin packing is done in the wrapper.
// PARAMETERS
//  CHANNELS  3  number of independent channels (>=1)
//  DATA_W    2  unsigned sample width per channel (>=1)
//  LOG2_WIN  2  window depth = 2^LOG2_WIN samples (>=1)
// PORTS
//  clk        in   1                        clock; all state changes on the rising edge
//  rst_n      in   1                        asynchronous reset, active low
//  in_valid   in   1                        in_data is accepted on this edge
//  in_data    in   CHANNELS*DATA_W          channel c = in_data[c*DATA_W +: DATA_W]
//  clear      in   1                        synchronous flush of window, sums and fill count
//  avg_mode   in   1                        1: rounded average; 0: raw window sum
//  out_en     in   1                        output gate; 0 forces out_data to zero
//  out_valid  out  1                        one-cycle pulse: new result on out_data
//  out_full   out  1                        window holds 2^LOG2_WIN accepted samples
//  out_data   out  CHANNELS*(DATA_W+LOG2_WIN)  channel c = out_data[c*SW +: SW], SW=DATA_W+LOG2_WIN
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous): window regs, sums and fill count go to 0;
//    out_valid, out_full and out_data go to 0.
//  - Per channel: shift register win[0..WIN-1] (DATA_W bits) and accumulator sum (SW bits).
//    SW bits hold WIN*(2^DATA_W-1) exactly; the sum never wraps.
//  - Accept edge (in_valid=1, clear=0):
//    sum <= sum + in - win[oldest]; shift in the new sample; drop the oldest.
//  - No accept (in_valid=0, clear=0): all state holds; out_valid <= 0.
//  - Before the window is full, unfilled slots read as 0, so sum = sum of samples accepted so far.
//  - fill counter: 0..WIN, +1 per accept, saturates at WIN. out_full = (fill == WIN), registered.
//  - clear=1: next edge zeroes window, sums, fill and out_valid. clear beats in_valid:
//    a sample presented with clear is dropped.
//  - out_valid is registered: high in the cycle after each accept edge, otherwise low.
//    Latency: one edge from accept to visible result.
//  - out_data is combinational from the registered sums, avg_mode and out_en:
//    - out_en=0: all zeros.
//    - avg_mode=0: the sum.
//    - avg_mode=1: (sum + 2^(LOG2_WIN-1)) >> LOG2_WIN, round half up, zero-extended to SW.
//      This cannot exceed 2^DATA_W-1, so no saturation is needed.
//  - avg_mode and out_en may change at any time; they affect only out_data, never state.
//    The average always divides by WIN, including during warm-up (partial windows under-read).
//  - Channels are fully independent; there is no cross-channel carry.
// TESTING  (defaults CHANNELS=3, DATA_W=2, LOG2_WIN=2, SW=4; out_en=1 unless stated)
//  1 Reset: rst_n=0 mid-clock, no edge -> out_data=0, out_valid=0, out_full=0 at once.
//  2 Fill: ch0=3, ch1=1, ch2=2, in_valid=1 for 4 cycles.
//    -> raw sums 12/4/8; out_full rises with the 4th result; avg_mode=1 -> 3/1/2.
//  3 Wrap: after test 2, accept ch0=0 -> ch0 raw 9, avg (9+2)>>2=2.
//    Four more zeros -> ch0=0, with no underflow at any step.
//  4 Gaps: alternate in_valid 1/0 -> out_valid pulses only after accept edges;
//    sums hold on idle cycles.
//  5 Flush: clear=1 with in_valid=1, ch0=3 -> next cycle sums=0, fill=0, out_full=0,
//    out_valid=0; the sample is dropped.
//  6 Gate/mode: toggle out_en and avg_mode mid-stream -> out_data changes in the same cycle;
//    sums and fill are unchanged. Repeat tests 2-3 with DATA_W=4, LOG2_WIN=3 vs a reference model.

Source files
------------

// File: rtl/multi_channel_moving_avg.sv
// N-channel boxcar moving-average filter.
// Full-width window sums, valid handshake, fill tracking, flush.
module multi_channel_moving_avg #(
  parameter int CHANNELS = 3,
  parameter int DATA_W   = 2,
  parameter int LOG2_WIN = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic [CHANNELS*DATA_W-1:0]        in_data,
  input  logic                              clear,
  input  logic                              avg_mode,
  input  logic                              out_en,
  output logic                              out_valid,
  output logic                              out_full,
  output logic [CHANNELS*(DATA_W+LOG2_WIN)-1:0] out_data
);

  localparam int WIN = 1 << LOG2_WIN;
  localparam int SW  = DATA_W + LOG2_WIN;
  localparam int FW  = LOG2_WIN + 1;

  localparam logic [FW-1:0] FILL_MAX = FW'(WIN);
  localparam logic [SW-1:0] HALF     = SW'(WIN / 2);

  logic [DATA_W-1:0] win_q [CHANNELS][WIN];
  logic [SW-1:0]     sum_q [CHANNELS];
  logic [SW-1:0]     sum_nxt [CHANNELS];
  logic [FW-1:0]     fill_q;
  logic [FW-1:0]     fill_nxt;
  logic              valid_q;
  logic              full_q;
  logic              accept;

  assign accept = in_valid & ~clear;

  // next running sum: true result always fits SW bits, so
  // modular add/sub gives the exact value without widening
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sum_nxt[c] = sum_q[c]
                 + SW'(in_data[c*DATA_W +: DATA_W])
                 - SW'(win_q[c][WIN-1]);
    end
  end

  // per-channel window shift and sum update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c] <= '0;
        for (int i = 0; i < WIN; i++)
          win_q[c][i] <= '0;
      end
    end else if (clear) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c] <= '0;
        for (int i = 0; i < WIN; i++)
          win_q[c][i] <= '0;
      end
    end else if (in_valid) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c]    <= sum_nxt[c];
        win_q[c][0] <= in_data[c*DATA_W +: DATA_W];
        for (int i = 1; i < WIN; i++)
          win_q[c][i] <= win_q[c][i-1];
      end
    end
  end

  // saturating fill count
  always_comb begin
    fill_nxt = fill_q;
    if (clear)
      fill_nxt = '0;
    else if (in_valid && fill_q != FILL_MAX)
      fill_nxt = fill_q + 1'b1;
  end

  // fill, full flag and result-valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q  <= '0;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      fill_q  <= fill_nxt;
      full_q  <= (fill_nxt == FILL_MAX);
      valid_q <= accept;
    end
  end

  assign out_valid = valid_q;
  assign out_full  = full_q;

  // output select: gate, raw sum or round-half-up average
  // (max sum + HALF stays below 2^SW, so no overflow)
  always_comb begin
    out_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (out_en) begin
        if (avg_mode)
          out_data[c*SW +: SW] = (sum_q[c] + HALF) >> LOG2_WIN;
        else
          out_data[c*SW +: SW] = sum_q[c];
      end
    end
  end

endmodule
